dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter NCORES, default 4, number of requesting cores (2..8).
REQ-002 Parameter AW, default 16, data-memory address width.
REQ-003 Parameter DW, default 16, data-memory word width.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NCORES  per-core access request, level.
REQ-007 we  input  NCORES  per-core write enable (1=write, 0=read), valid with req.
REQ-008 addr  input  NCORES*AW  per-core address, core i in bits [i*AW +: AW].
REQ-009 wdata  input  NCORES*DW  per-core write data, core i in bits [i*DW +: DW].
REQ-010 gnt  output  NCORES  one-hot grant pulse, one cycle.
REQ-011 rvalid  output  NCORES  one-hot read-data-valid pulse, one cycle.
REQ-012 rdata  output  DW  read data, broadcast to all cores, qualified by rvalid.
REQ-013 mem_en  output  1  data-memory access strobe.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_addr  output  AW  data-memory address.
REQ-016 mem_wdata  output  DW  data-memory write data.
REQ-017 mem_rdata  input  DW  data-memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE: no req -> stay IDLE; any req -> select winner, register idx/we/addr/wdata of winner, go ACCESS.
REQ-020 Winner: first asserted req[i] scanning i = ptr, ptr+1, ... modulo NCORES.
REQ-021 ptr resets to 0; at each selection ptr <= (winner+1) mod NCORES.
REQ-022 ACCESS (exactly one cycle): gnt[idx]=1, mem_en=1, mem_we/mem_addr/mem_wdata = registered values.
REQ-023 ACCESS with write -> IDLE; with read -> RESP.
REQ-024 RESP (exactly one cycle): rdata registered from mem_rdata, rvalid[idx]=1 in the cycle after RESP is entered's capture, i.e. rvalid and rdata both asserted during RESP+1 edge output; total read latency req-selected to rvalid = 3 cycles; RESP -> IDLE.
REQ-025 Write occupancy 2 cycles (IDLE, ACCESS); read occupancy 3 cycles (IDLE, ACCESS, RESP).
REQ-026 Core SHALL hold req/we/addr/wdata stable until it samples gnt=1 and SHALL drop req at that edge; arbiter therefore never re-selects the same access.
REQ-027 Request values are sampled only in IDLE; changes to req/we/addr/wdata after selection have no effect on the access in flight.
REQ-028 req withdrawn before selection: no access, no gnt.
REQ-029 All outputs other than those named active in REQ-022/REQ-024 are 0; mem_addr/mem_wdata hold last value outside ACCESS; gnt and rvalid never assert simultaneously.
REQ-030 Fairness: a continuously requesting core is granted within NCORES consecutive accesses.
REQ-031 rdata holds last read value until next RESP.

Reset
REQ-032 reset_n low forces IDLE, ptr=0, gnt=0, rvalid=0, mem_en=0, mem_we=0, rdata=0, mem_addr=0, mem_wdata=0, immediately without clock.
REQ-033 Reset mid-ACCESS or mid-RESP aborts the access: no gnt/rvalid after reset; first grant after release follows ptr=0.

Verification
REQ-034 Single write: core2 req, we=1, addr=0x0010, wdata=0x1234 -> next cycle gnt=4'b0100, mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234; IDLE after.
REQ-035 Single read: core1 read addr=0x0005, memory returns 0x00AB -> gnt=4'b0010 then rvalid=4'b0010 with rdata=0x00AB, no other rvalid.
REQ-036 All four cores request writes at once after reset, each re-requesting -> grant order 0,1,2,3,0,1 at 2-cycle spacing.
REQ-037 Core3 and core0 request with ptr=2 -> core3 granted first, then core0; ptr=1 afterwards.
REQ-038 reset_n pulled low during RESP of core1 read -> rvalid stays 0, mem_en=0; after release core0 req granted first.
REQ-039 Core changes addr from 0x0001 to 0x0002 in ACCESS cycle -> mem_addr=0x0001 for that access.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving NCORES cores shared access to one single-port data memory.
// Writes occupy the memory port for two cycles, reads for three (the last returns rdata).
module dm_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   ptr_nxt;
    logic            win_found;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (!win_found && req[(int'(ptr) + k) % NCORES]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr) + k) % NCORES);
            end
        end
        ptr_nxt = (win_idx == IW'(NCORES - 1)) ? '0 : win_idx + IW'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = ACCESS;
            ACCESS:  state_nxt = mem_we ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Strobes default low each cycle; the access registers double as mem_addr/mem_wdata and hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            idx       <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        ptr       <= ptr_nxt;
                        idx       <= win_idx;
                        gnt       <= NCORES'(1) << win_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[win_idx];
                        mem_addr  <= addr[int'(win_idx)*AW +: AW];
                        mem_wdata <= wdata[int'(win_idx)*DW +: DW];
                    end
                end
                RESP: begin
                    rdata  <= mem_rdata;
                    rvalid <= NCORES'(1) << idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus random core traffic, compared
// cycle by cycle against a transaction-level model (rotation scan + occupancy arithmetic).
module tb_dm_arbiter;

    localparam int NC   = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXC = 1024;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [NC-1:0]    req;
    logic [NC-1:0]    we;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]    gnt;
    logic [NC-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;

    dm_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory device attached to the DUT; ref_mem is the model's own copy.
    logic [DW-1:0] dev_mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr[7:0]];
        end
    end

    // Expected outputs per cycle since the last reset release.
    logic [NC-1:0] e_gnt [MAXC];
    logic [NC-1:0] e_rv  [MAXC];
    logic          e_en  [MAXC];
    logic          e_we  [MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [DW-1:0] e_wd  [MAXC];
    logic [DW-1:0] e_rd  [MAXC];

    int k, ptr_m, free_at;
    int n_checks = 0;
    int n_errors = 0;
    bit auto_rereq = 1'b0;
    bit rand_mode  = 1'b0;

    int            obs_g[$];
    int            obs_gc[$];
    logic [AW-1:0] obs_ga[$];
    int            obs_rv[$];
    int            obs_rvc[$];
    logic [DW-1:0] obs_rd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_set(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_obs();
        obs_g.delete(); obs_gc.delete(); obs_ga.delete();
        obs_rv.delete(); obs_rvc.delete(); obs_rd.delete();
    endtask

    task automatic model_reset();
        k = 0; ptr_m = 0; free_at = 1;
        for (int c = 0; c < MAXC; c++) begin
            e_gnt[c] = '0; e_rv[c] = '0; e_en[c] = 1'b0; e_we[c] = 1'b0;
            e_addr[c] = '0; e_wd[c] = '0; e_rd[c] = '0;
        end
        req = '0; we = '0;
        clear_obs();
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic new_random(input int i);
        set_req(i, 1'($urandom_range(1)), AW'($urandom_range(255)), DW'($urandom));
    endtask

    task automatic check_outputs();
        check($sformatf("gnt@%0d", k),       gnt,       e_gnt[k]);
        check($sformatf("rvalid@%0d", k),    rvalid,    e_rv[k]);
        check($sformatf("mem_en@%0d", k),    mem_en,    e_en[k]);
        check($sformatf("mem_we@%0d", k),    mem_we,    e_we[k]);
        check($sformatf("mem_addr@%0d", k),  mem_addr,  e_addr[k]);
        check($sformatf("mem_wdata@%0d", k), mem_wdata, e_wd[k]);
        check($sformatf("rdata@%0d", k),     rdata,     e_rd[k]);
        if (gnt != '0)    begin obs_g.push_back(first_set(gnt)); obs_gc.push_back(k); obs_ga.push_back(mem_addr); end
        if (rvalid != '0) begin obs_rv.push_back(first_set(rvalid)); obs_rvc.push_back(k); obs_rd.push_back(rdata); end
    endtask

    // Cores drop req once granted (or re-request); random mode adds new requests and withdrawals.
    task automatic update_agents();
        for (int i = 0; i < NC; i++) begin
            if (e_gnt[k][i]) begin
                if (auto_rereq) req[i] = 1'b1;
                else if (rand_mode && $urandom_range(1) == 1) new_random(i);
                else req[i] = 1'b0;
            end else if (rand_mode) begin
                if (!req[i] && $urandom_range(3) == 0) new_random(i);
                else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
            end
        end
    endtask

    // Predicts the outputs of cycle k+1 from the requests sampled at the coming edge.
    task automatic model_step();
        int n, w;
        logic [AW-1:0] a;
        n = k + 1;
        e_addr[n] = e_addr[k];
        e_wd[n]   = e_wd[k];
        if (e_rv[n] == '0) e_rd[n] = e_rd[k];
        if (n >= free_at && req != '0) begin
            w = -1;
            for (int j = 0; j < NC; j++) if (w < 0 && req[(ptr_m + j) % NC]) w = (ptr_m + j) % NC;
            a = addr[w*AW +: AW];
            e_gnt[n]  = NC'(1) << w;
            e_en[n]   = 1'b1;
            e_we[n]   = we[w];
            e_addr[n] = a;
            e_wd[n]   = wdata[w*DW +: DW];
            ptr_m     = (w + 1) % NC;
            if (we[w]) begin
                ref_mem[a[7:0]] = e_wd[n];
                free_at = n + 2;
            end else begin
                e_rv[n+2] = NC'(1) << w;
                e_rd[n+2] = ref_mem[a[7:0]];
                free_at = n + 3;
            end
        end
    endtask

    task automatic tick();
        if (k >= MAXC - 4) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", k, MAXC - 4);
            $fatal(1, "cycle budget exceeded");
        end
        check_outputs();
        update_agents();
        model_step();
        @(posedge clock);
        k++;
        @(negedge clock);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic apply_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_gnt", gnt, '0);
        check("rst_rvalid", rvalid, '0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_rdata", rdata, '0);
        repeat (2) @(negedge clock);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = DW'(i * 37 + 11);
            ref_mem[i] = DW'(i * 37 + 11);
        end
        @(negedge clock);
        apply_reset();

        // Single write from core 2.
        set_req(2, 1'b1, 16'h0010, 16'h1234);
        repeat (4) tick();
        check("w_count", obs_g.size(), 1);
        if (obs_g.size() >= 1) begin
            check("w_core", obs_g[0], 2);
            check("w_cycle", obs_gc[0], 1);
            check("w_addr", obs_ga[0], 16'h0010);
        end
        check("w_mem", dev_mem[16], 16'h1234);

        // Single read from core 1.
        clear_obs();
        dev_mem[5] = 16'h00AB;
        ref_mem[5] = 16'h00AB;
        set_req(1, 1'b0, 16'h0005, 16'h0000);
        repeat (5) tick();
        check("r_count", obs_g.size(), 1);
        check("r_rv_count", obs_rv.size(), 1);
        if (obs_g.size() >= 1 && obs_rv.size() >= 1) begin
            check("r_gnt_core", obs_g[0], 1);
            check("r_rv_core", obs_rv[0], 1);
            check("r_data", obs_rd[0], 16'h00AB);
            check("r_latency", obs_rvc[0] - obs_gc[0], 2);
        end

        // All four cores keep re-requesting writes.
        apply_reset();
        auto_rereq = 1'b1;
        for (int i = 0; i < NC; i++) set_req(i, 1'b1, AW'(32 + i), DW'(16'h5A00 + i));
        repeat (12) tick();
        auto_rereq = 1'b0;
        req = '0;
        repeat (2) tick();
        check("rr_count", obs_g.size(), 6);
        for (int j = 0; j < 6 && j < obs_g.size(); j++) begin
            check($sformatf("rr_core%0d", j), obs_g[j], j % NC);
            check($sformatf("rr_cycle%0d", j), obs_gc[j], 1 + 2 * j);
        end

        // ptr at 2: cores 3 and 0 contend, then cores 0 and 1 with ptr at 1.
        apply_reset();
        set_req(1, 1'b1, 16'h0030, 16'h0001);
        repeat (3) tick();
        set_req(3, 1'b1, 16'h0033, 16'h0003);
        set_req(0, 1'b1, 16'h0034, 16'h0004);
        repeat (5) tick();
        set_req(0, 1'b0, 16'h0035, 16'h0000);
        set_req(1, 1'b1, 16'h0036, 16'h0006);
        repeat (7) tick();
        check("ptr_count", obs_g.size(), 5);
        if (obs_g.size() >= 5) begin
            check("ptr_g0", obs_g[0], 1);
            check("ptr_g1", obs_g[1], 3);
            check("ptr_g2", obs_g[2], 0);
            check("ptr_g3", obs_g[3], 1);
            check("ptr_g4", obs_g[4], 0);
        end

        // Reset during the RESP cycle of a core 1 read.
        apply_reset();
        set_req(1, 1'b0, 16'h0007, 16'h0000);
        repeat (2) tick();
        apply_reset();
        repeat (2) tick();
        set_req(3, 1'b1, 16'h0040, 16'h0303);
        set_req(0, 1'b1, 16'h0041, 16'h0000);
        repeat (6) tick();
        check("ab_rv_count", obs_rv.size(), 0);
        check("ab_count", obs_g.size(), 2);
        if (obs_g.size() >= 1) check("ab_first", obs_g[0], 0);

        // Address changed by core 0 during its ACCESS cycle.
        clear_obs();
        set_req(0, 1'b1, 16'h0001, 16'hBEEF);
        tick();
        addr[0 +: AW] = 16'h0002;
        repeat (3) tick();
        check("hold_count", obs_g.size(), 1);
        if (obs_ga.size() >= 1) check("hold_addr", obs_ga[0], 16'h0001);
        check("hold_mem1", dev_mem[1], 16'hBEEF);
        check("hold_mem2", dev_mem[2], ref_mem[2]);

        // Random traffic.
        apply_reset();
        rand_mode = 1'b1;
        repeat (600) tick();
        rand_mode = 1'b0;
        req = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
